weight_update_feeder: RTL and testbench

Sits between the backpropagator's `dc_dw` stream output and the weight storage update interface. It buffers incoming gradient words, scales each lane by a runtime learning rate, and tags each word with its layer/row position. It then issues one weight-storage update per word through a stall-aware handshake. Gradients arrive last-layer-first, so layer indices count down and row indices count up.

---
 rtl/weight_update_feeder.sv | 156 +++++++++++++++
 tb/tb_weight_update_feeder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_update_feeder.sv
// Gradient-word FIFO, per-lane learning-rate scaling and layer/row tagging ahead of weight storage.
// Define WEIGHT_UPDATE_SATURATE_EN to clamp scaled lanes to signed 16-bit instead of wrapping.
module weight_update_feeder #(
    parameter int DATA_WIDTH     = 48,
    parameter int LANE_WIDTH     = 16,
    parameter int FRAC_BITS      = 8,
    parameter int FIFO_DEPTH     = 8,
    parameter int ROWS_PER_LAYER = 4,
    parameter int NUM_LAYERS     = 3
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic                  dc_dw_valid,
    input  logic [DATA_WIDTH-1:0] dc_dw_stream,
    output logic                  dc_dw_ready,
    input  logic [15:0]           learning_rate,
    input  logic                  epoch_start,
    input  logic                  update_stall,
    output logic                  is_update,
    output logic [DATA_WIDTH-1:0] dc_dw,
    output logic [31:0]           layer_index,
    output logic [31:0]           row_index,
    output logic                  epoch_done
);

    localparam int NLANES = DATA_WIDTH / LANE_WIDTH;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int PW     = LANE_WIDTH + 17;  // signed lane x zero-extended 16-bit rate
    localparam logic signed [PW:0] HALF = (PW+1)'(1 << (FRAC_BITS-1));

    typedef enum logic [1:0] {IDLE, SCALE, ISSUE} state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [AW:0]             cnt_q;
    logic signed [PW-1:0]    prod_q [NLANES];
    logic                    is_update_q;
    logic [DATA_WIDTH-1:0]   dc_dw_q;
    logic [31:0]             layer_q, row_q;
    logic                    clr_pend_q;
    logic [DATA_WIDTH-1:0]   head;
    logic [DATA_WIDTH-1:0]   scaled;
    logic                    push, pop, complete, last_pos;

    assign dc_dw_ready = (cnt_q != (AW+1)'(FIFO_DEPTH));
    assign push        = dc_dw_valid && dc_dw_ready;
    assign pop         = (state_q == IDLE) && (cnt_q != '0);
    assign head        = mem_q[rd_ptr_q];
    assign complete    = is_update_q && !update_stall;
    assign last_pos    = (layer_q == '0) && (row_q == 32'(ROWS_PER_LAYER-1));

    assign is_update   = is_update_q;
    assign dc_dw       = dc_dw_q;
    assign layer_index = layer_q;
    assign row_index   = row_q;
    assign epoch_done  = reset_reset_n && complete && last_pos;

    always_ff @(posedge clk_clk) begin
        if (push) mem_q[wr_ptr_q] <= dc_dw_stream;
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

`ifdef WEIGHT_UPDATE_SATURATE_EN
    localparam logic signed [PW:0] SAT_MAX = (PW+1)'((1 << (LANE_WIDTH-1)) - 1);
    localparam logic signed [PW:0] SAT_MIN = ~SAT_MAX;
    logic signed [PW:0] shr [NLANES];

    always_comb begin
        scaled = '0;
        for (int k = 0; k < NLANES; k++) begin
            shr[k] = (prod_q[k] + HALF) >>> FRAC_BITS;
            if (shr[k] > SAT_MAX)
                scaled[k*LANE_WIDTH +: LANE_WIDTH] = LANE_WIDTH'(SAT_MAX);
            else if (shr[k] < SAT_MIN)
                scaled[k*LANE_WIDTH +: LANE_WIDTH] = LANE_WIDTH'(SAT_MIN);
            else
                scaled[k*LANE_WIDTH +: LANE_WIDTH] = LANE_WIDTH'(shr[k]);
        end
    end
`else
    always_comb begin
        scaled = '0;
        for (int k = 0; k < NLANES; k++)
            scaled[k*LANE_WIDTH +: LANE_WIDTH] = LANE_WIDTH'((prod_q[k] + HALF) >>> FRAC_BITS);
    end
`endif

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q     <= IDLE;
            is_update_q <= 1'b0;
            dc_dw_q     <= '0;
            layer_q     <= 32'(NUM_LAYERS-1);
            row_q       <= '0;
            clr_pend_q  <= 1'b0;
            for (int k = 0; k < NLANES; k++) prod_q[k] <= '0;
        end else begin
            case (state_q)
                IDLE: if (pop) begin
                    for (int k = 0; k < NLANES; k++)
                        prod_q[k] <= PW'($signed(head[k*LANE_WIDTH +: LANE_WIDTH]))
                                   * PW'($signed({1'b0, learning_rate}));
                    state_q <= SCALE;
                end
                SCALE: begin
                    dc_dw_q     <= scaled;
                    is_update_q <= 1'b1;
                    state_q     <= ISSUE;
                end
                ISSUE: if (!update_stall) begin
                    is_update_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            // Tags must hold while an update waits, so a clear seen then is deferred to completion.
            if (complete) begin
                clr_pend_q <= 1'b0;
                if (epoch_start || clr_pend_q) begin
                    row_q   <= '0;
                    layer_q <= 32'(NUM_LAYERS-1);
                end else if (row_q == 32'(ROWS_PER_LAYER-1)) begin
                    row_q   <= '0;
                    layer_q <= (layer_q == '0) ? 32'(NUM_LAYERS-1) : layer_q - 32'd1;
                end else begin
                    row_q <= row_q + 32'd1;
                end
            end else if (epoch_start) begin
                if (state_q == ISSUE) begin
                    clr_pend_q <= 1'b1;
                end else begin
                    row_q   <= '0;
                    layer_q <= 32'(NUM_LAYERS-1);
                end
            end
        end
    end

endmodule

// File: tb/tb_weight_update_feeder.sv
// Scoreboard bench for weight_update_feeder: stimulus pushes expected words, a negedge monitor checks updates.
module tb_weight_update_feeder;
  localparam int DEPTH = 8, ROWS = 4, LAYERS = 3;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        dc_dw_valid;
  logic [47:0] dc_dw_stream;
  logic        dc_dw_ready;
  logic [15:0] learning_rate;
  logic        epoch_start;
  logic        update_stall;
  logic        is_update;
  logic [47:0] dc_dw;
  logic [31:0] layer_index, row_index;
  logic        epoch_done;

  weight_update_feeder dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .dc_dw_valid(dc_dw_valid), .dc_dw_stream(dc_dw_stream), .dc_dw_ready(dc_dw_ready),
    .learning_rate(learning_rate), .epoch_start(epoch_start), .update_stall(update_stall),
    .is_update(is_update), .dc_dw(dc_dw), .layer_index(layer_index), .row_index(row_index),
    .epoch_done(epoch_done)
  );

  always #5 clk_clk = ~clk_clk;

  int errors = 0, checks = 0;
  logic [47:0] exp_q[$];
  int idx = 0;            // updates completed since last epoch clear
  int accepted_cnt = 0, drop_at = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: signed lane times unsigned Q8.8 rate, round half up, shift, then clamp or wrap.
  function automatic logic [47:0] model(input logic [47:0] w, input logic [15:0] lr);
    logic [47:0] o;
    longint p, r;
    for (int k = 0; k < 3; k++) begin
      p = longint'($signed(w[k*16 +: 16])) * longint'(lr);
      r = (p + 128) >>> 8;
`ifdef WEIGHT_UPDATE_SATURATE_EN
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
`endif
      o[k*16 +: 16] = r[15:0];
    end
    return o;
  endfunction

  // Monitor: compare every completed update with the scoreboard and position model.
  logic        held_v = 1'b0;
  logic [111:0] held;
  always @(negedge clk_clk) begin
    logic [47:0] e;
    if (!reset_reset_n) begin
      exp_q.delete();
      idx = 0;
      held_v = 1'b0;
    end else begin
      if (is_update && held_v) check("stall_frozen", {dc_dw, layer_index, row_index}, held);
      held_v = is_update && update_stall;
      held = {dc_dw, layer_index, row_index};
      if (is_update && !update_stall) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_update: got dc_dw %h expected no update", dc_dw);
        end else begin
          e = exp_q.pop_front();
          check("dc_dw", dc_dw, e);
          check("layer", layer_index, LAYERS - 1 - (idx / ROWS) % LAYERS);
          check("row", row_index, idx % ROWS);
        end
        check("epoch_done", epoch_done, (idx % (ROWS*LAYERS)) == ROWS*LAYERS - 1);
        idx = epoch_start ? 0 : idx + 1;
      end else begin
        if (epoch_done) begin
          checks++; errors++;
          $display("FAIL spurious_epoch_done: got 1 expected 0");
        end
        if (epoch_start) idx = 0;
      end
    end
  end

  task automatic send(input logic [47:0] w);
    bit ok = 0;
    dc_dw_valid = 1'b1;
    dc_dw_stream = w;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk_clk);
      if (dc_dw_ready) begin ok = 1; break; end
      if (drop_at < 0) drop_at = accepted_cnt;
    end
    if (ok) begin
      exp_q.push_back(model(w, learning_rate));
      accepted_cnt++;
      @(posedge clk_clk); #1;
    end else begin
      checks++; errors++;
      $display("FAIL send_timeout: got ready 0 expected 1");
    end
    dc_dw_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk_clk);
      if (exp_q.size() == 0 && !is_update) begin ok = 1; break; end
    end
    check("drain", ok, 1'b1);
    @(posedge clk_clk); #1;
  endtask

  task automatic pulse_epoch();
    epoch_start = 1'b1;
    @(posedge clk_clk); #1;
    epoch_start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_is_update"}, is_update, 1'b0);
    check({tag, "_dc_dw"}, dc_dw, 48'h0);
    check({tag, "_layer"}, layer_index, LAYERS - 1);
    check({tag, "_row"}, row_index, 0);
    check({tag, "_epoch_done"}, epoch_done, 1'b0);
    check({tag, "_ready"}, dc_dw_ready, 1'b1);
  endtask

  initial begin
    logic [47:0] w;
    int seen;
    reset_reset_n = 1'b0; dc_dw_valid = 1'b0; dc_dw_stream = '0;
    learning_rate = 16'h0080; epoch_start = 1'b0; update_stall = 1'b0;
    repeat (3) @(posedge clk_clk);
    #1;
    check_reset_outputs("reset");
    reset_reset_n = 1'b1;
    @(posedge clk_clk); #1;

    // Basic scaling and latency: accepted at edge N, visible after edge N+2 (during cycle N+3).
    send({16'h0000, 16'hFF00, 16'h0100});
    check("lat_n0", is_update, 1'b0);
    @(posedge clk_clk); #1;
    check("lat_n1", is_update, 1'b0);
    @(posedge clk_clk); #1;
    check("lat_n2", is_update, 1'b1);
    check("basic_dc_dw", dc_dw, {16'h0000, 16'hFF80, 16'h0080});
    check("basic_layer", layer_index, 2);
    check("basic_row", row_index, 0);
    drain();

    // Overflow of a single lane.
    learning_rate = 16'h0200;
    send({32'h0, 16'h7FFF});
    repeat (2) @(posedge clk_clk);
    #1;
`ifdef WEIGHT_UPDATE_SATURATE_EN
    check("overflow_lane", dc_dw[15:0], 16'h7FFF);
`else
    check("overflow_lane", dc_dw[15:0], 16'hFFFE);
`endif
    drain();

    // Ordering across a full epoch plus one.
    pulse_epoch();
    learning_rate = 16'($urandom_range(0, 16'h03FF));
    for (int i = 0; i < 13; i++) send({$urandom, 16'($urandom)});
    drain();

    // Backpressure: one word held in the datapath plus a full FIFO before ready drops.
    update_stall = 1'b1;
    accepted_cnt = 0; drop_at = -1;
    fork
      begin repeat (20) @(posedge clk_clk); #1; update_stall = 1'b0; end
      begin for (int i = 0; i < 10; i++) send({$urandom, 16'($urandom)}); end
    join
    check("ready_drop_at", drop_at, DEPTH + 1);
    drain();

    // Random stream with random stalls and a random rate.
    learning_rate = 16'($urandom);
    fork
      begin
        repeat (150) begin @(posedge clk_clk); #1; update_stall = ($urandom_range(0, 3) == 0); end
        update_stall = 1'b0;
      end
      begin for (int i = 0; i < 24; i++) send({$urandom, 16'($urandom)}); end
    join
    drain();

    // Epoch restart colliding with completion of (1,2).
    pulse_epoch();
    learning_rate = 16'h0100;
    for (int i = 0; i < 6; i++) begin send({$urandom, 16'($urandom)}); drain(); end
    send({$urandom, 16'($urandom)});
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(posedge clk_clk); #1;
      if (is_update) seen = 1;
    end
    check("collide_seen", seen, 1);
    check("collide_layer", layer_index, 1);
    check("collide_row", row_index, 2);
    pulse_epoch();
    send({$urandom, 16'($urandom)});
    repeat (2) @(posedge clk_clk);
    #1;
    check("after_collide_layer", layer_index, 2);
    check("after_collide_row", row_index, 0);
    drain();

    // Reset while stalled in ISSUE with 5 words buffered.
    update_stall = 1'b1;
    for (int i = 0; i < 6; i++) send({$urandom, 16'($urandom)});
    reset_reset_n = 1'b0;
    @(posedge clk_clk); #1;
    check_reset_outputs("midreset");
    reset_reset_n = 1'b1;
    update_stall = 1'b0;
    seen = 0;
    repeat (10) begin @(posedge clk_clk); #1; if (is_update) seen = 1; end
    check("no_stale_update", seen, 0);
    w = {16'h0100, 16'h0200, 16'hFE00};
    send(w);
    repeat (2) @(posedge clk_clk);
    #1;
    check("post_reset_update", is_update, 1'b1);
    check("post_reset_layer", layer_index, 2);
    check("post_reset_row", row_index, 0);
    drain();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
